mips_multicycle_control: RTL

//  Moore control FSM for the multicycle MIPS datapath. Consumes the 6-bit opcode (Operation) and the funct field

---
 rtl/mips_multicycle_control.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore control FSM sequencing the multicycle MIPS datapath.
// Define MIPS_CTRL_ILLEGAL_OP_TRAP_EN to make illegal instructions trap until Reset instead of being skipped.
module mips_multicycle_control #(
   parameter int MEM_WAIT = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [5:0] Operation,
   input  logic [5:0] Funct,
   input  logic       ALU_zero,
   output logic       pc_reset,
   output logic       instReg_reset,
   output logic       a_reset,
   output logic       b_reset,
   output logic       ALUout_reset,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       pc_load,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       a_load,
   output logic       b_load,
   output logic       ALUout_load,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALU_select,
   output logic [1:0] PCSource,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       trap,
   output logic [3:0] state_dbg
);
   localparam int WW = $clog2(MEM_WAIT) + 1;
   typedef enum logic [3:0] {
      RST, FETCH, DECODE, R_EX, R_WB, MEM_ADR, MEM_RD, LW_WB,
      MEM_WR, ADDI_EX, ADDI_WB, BRANCH, JUMP, ILLEGAL
   } state_t;
   state_t state, state_n;
   logic [WW-1:0] wcnt;
   logic wait_done;
   logic [2:0] alu_f;
   logic funct_ok;
   assign wait_done = wcnt == WW'(MEM_WAIT - 1);
   assign alu_f = Funct == 6'h20 ? 3'b001 :
                  Funct == 6'h22 ? 3'b010 :
                  Funct == 6'h24 ? 3'b011 :
                  Funct == 6'h26 ? 3'b110 : 3'b000;
   assign funct_ok = alu_f != 3'b000;
   // opcode bit 0 separates BNE (05) from BEQ (04)
   assign pc_load = PCWrite | (PCWriteCond & (ALU_zero ^ Operation[0]));
   assign state_dbg = state;
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= RST;
         wcnt  <= '0;
      end else begin
         state <= state_n;
         wcnt  <= (state_n == state && (state == FETCH || state == MEM_RD)) ? wcnt + WW'(1) : '0;
      end
   end
   always_comb begin
      state_n = RST;
      case (state)
         RST:     state_n = FETCH;
         FETCH:   state_n = wait_done ? DECODE : FETCH;
         DECODE:  state_n = Operation == 6'h00 ? R_EX :
                            (Operation == 6'h23 || Operation == 6'h2B) ? MEM_ADR :
                            (Operation == 6'h04 || Operation == 6'h05) ? BRANCH :
                            Operation == 6'h08 ? ADDI_EX :
                            Operation == 6'h02 ? JUMP : ILLEGAL;
         R_EX:    state_n = funct_ok ? R_WB : ILLEGAL;
         MEM_ADR: state_n = Operation == 6'h23 ? MEM_RD : MEM_WR;
         MEM_RD:  state_n = wait_done ? LW_WB : MEM_RD;
         ADDI_EX: state_n = ADDI_WB;
         R_WB, LW_WB, MEM_WR, ADDI_WB, BRANCH, JUMP: state_n = FETCH;
`ifdef MIPS_CTRL_ILLEGAL_OP_TRAP_EN
         ILLEGAL: state_n = ILLEGAL;
`else
         ILLEGAL: state_n = FETCH;
`endif
         default: state_n = RST;
      endcase
   end
   always_comb begin
      {pc_reset, instReg_reset, a_reset, b_reset, ALUout_reset} = '0;
      {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite} = '0;
      {a_load, b_load, ALUout_load, ALUSrcA} = '0;
      ALUSrcB    = 2'b00;
      ALU_select = 3'b000;
      PCSource   = 2'b00;
      {RegDst, MemtoReg, RegWrite, trap} = '0;
      case (state)
         RST: {pc_reset, instReg_reset, a_reset, b_reset, ALUout_reset} = '1;
         FETCH: begin
            MemRead = 1'b1;
            if (wait_done) begin
               {IRWrite, PCWrite} = '1;
               ALUSrcB    = 2'b01;
               ALU_select = 3'b001;
            end
         end
         DECODE: begin
            {a_load, b_load, ALUout_load} = '1;
            ALUSrcB    = 2'b11;
            ALU_select = 3'b001;
         end
         R_EX: begin
            {ALUSrcA, ALUout_load} = '1;
            ALU_select = alu_f;
         end
         R_WB: {RegDst, RegWrite} = '1;
         MEM_ADR, ADDI_EX: begin
            {ALUSrcA, ALUout_load} = '1;
            ALUSrcB    = 2'b10;
            ALU_select = 3'b001;
         end
         MEM_RD:  {IorD, MemRead} = '1;
         LW_WB:   {MemtoReg, RegWrite} = '1;
         MEM_WR:  {IorD, MemWrite} = '1;
         ADDI_WB: RegWrite = 1'b1;
         BRANCH: begin
            {ALUSrcA, PCWriteCond} = '1;
            ALU_select = 3'b010;
            PCSource   = 2'b01;
         end
         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
`ifdef MIPS_CTRL_ILLEGAL_OP_TRAP_EN
         ILLEGAL: trap = 1'b1;
`endif
         default: ;
      endcase
   end
endmodule
